// File: rtl/repetition_encoder.sv
// repetition_encoder: covert-channel transmitter for the repetition detector.
// Each packet slot receives a field value. A repeat of the previous field carries a
// payload '1' and a fresh LFSR-derived value carries a '0'. With no byte in flight,
// slots get fresh filler values.
//
// Optional feature macro: REP_ENC_PREAMBLE_EN
//   When defined, each accepted byte is preceded by PREAMBLE_LEN repeat slots. This
//   burst marks the start of a byte for the receiver. When undefined, the preamble
//   state and its counter are not built.
//
// States:
//   state    | meaning
//   IDLE     | s_ready=1, slots get fresh filler, waiting for a byte
//   SEND     | s_ready=0, each slot carries shreg[bit_idx], MSB first
//   PREAMBLE | s_ready=0, each slot repeats last value (macro builds only)
module repetition_encoder #(
  parameter int          FIELD_SIZE   = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          PREAMBLE_LEN = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  slot,
  output logic [FIELD_SIZE-1:0] field,
  output logic                  field_valid,
  output logic [15:0]           bits_sent
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef REP_ENC_PREAMBLE_EN
  localparam logic [1:0] ST_PRE  = 2'd2;
  localparam int         PCW     = (PREAMBLE_LEN > 2) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PCW-1:0] PRE_LOAD = PCW'(PREAMBLE_LEN - 1);
`endif

  localparam logic [FIELD_SIZE-1:0] FIELD_ONE = {{(FIELD_SIZE-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [7:0]            shreg_q;
  logic [2:0]            bit_idx_q;
  logic [15:0]           lfsr_q;
  logic [15:0]           lfsr_next;
  logic [FIELD_SIZE-1:0] field_q;
  logic                  field_valid_q;
  logic [15:0]           bits_sent_q;
`ifdef REP_ENC_PREAMBLE_EN
  logic [PCW-1:0]        pre_cnt_q;
`endif

  logic                  accept;
  logic                  emit;
  logic                  emit_repeat;
  logic                  emit_payload;
  logic [FIELD_SIZE-1:0] cand;
  logic [FIELD_SIZE-1:0] fresh_val;

  assign s_ready = (state_q == ST_IDLE);
  assign accept  = s_valid & s_ready;
  assign emit    = slot & enable;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; only consumed when a fresh value goes out.
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand      = lfsr_next[FIELD_SIZE-1:0];
  // A fresh value must never look like a repeat, so collide-by-chance is bumped by one.
  assign fresh_val = (cand == field_q) ? (field_q + FIELD_ONE) : cand;

  // Decide what the current slot carries.
  always_comb begin
    emit_repeat  = 1'b0;
    emit_payload = 1'b0;
    case (state_q)
      ST_SEND: begin
        emit_repeat  = shreg_q[bit_idx_q];
        emit_payload = 1'b1;
      end
`ifdef REP_ENC_PREAMBLE_EN
      ST_PRE:  emit_repeat = 1'b1;
`endif
      default: begin
        emit_repeat  = 1'b0;
        emit_payload = 1'b0;
      end
    endcase
  end

  // Next-state logic; slot-driven transitions only advance while enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef REP_ENC_PREAMBLE_EN
          state_d = ST_PRE;
`else
          state_d = ST_SEND;
`endif
        end
      end
      ST_SEND: begin
        if (emit && (bit_idx_q == 3'd0)) state_d = ST_IDLE;
      end
`ifdef REP_ENC_PREAMBLE_EN
      ST_PRE: begin
        if (emit && (pre_cnt_q == '0)) state_d = ST_SEND;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus byte shift register and bit index.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shreg_q   <= s_data;
        bit_idx_q <= 3'd7;
      end else if (emit && (state_q == ST_SEND)) begin
        bit_idx_q <= bit_idx_q - 3'd1;
      end
    end
  end

`ifdef REP_ENC_PREAMBLE_EN
  // Preamble down-counter: loaded on accept, terminal count at zero ends the burst.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
    end else if (accept) begin
      pre_cnt_q <= PRE_LOAD;
    end else if (emit && (state_q == ST_PRE) && (pre_cnt_q != '0)) begin
      pre_cnt_q <= pre_cnt_q - 1'b1;
    end
  end
`endif

  // Emission path: field value, its qualifier, LFSR advance and payload bit count.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q        <= LFSR_SEED;
      field_q       <= '0;
      field_valid_q <= 1'b0;
      bits_sent_q   <= 16'h0000;
    end else begin
      field_valid_q <= emit;
      if (emit) begin
        if (!emit_repeat) begin
          field_q <= fresh_val;
          lfsr_q  <= lfsr_next;
        end
        if (emit_payload) bits_sent_q <= bits_sent_q + 16'h0001;
      end
    end
  end

  assign field       = field_q;
  assign field_valid = field_valid_q;
  assign bits_sent   = bits_sent_q;

endmodule

// File: tb/tb_repetition_encoder.sv
// Directed bench for repetition_encoder. Main instance uses default parameters; a
// second 8-bit instance with a chosen seed exercises the collision bump and its wrap.
module tb_repetition_encoder;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] SEED8 = 16'h827F;
  localparam int          PLEN  = 4;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        slot    = 1'b0;
  logic [15:0] field;
  logic        field_valid;
  logic [15:0] bits_sent;

  logic        enable8 = 1'b0;
  logic        slot8   = 1'b0;
  logic        s_ready8;
  logic [7:0]  field8;
  logic        field_valid8;
  logic [15:0] bits_sent8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  int          m_bits;

  always #5 sys_clk = ~sys_clk;

  repetition_encoder #(.FIELD_SIZE(16), .LFSR_SEED(SEED), .PREAMBLE_LEN(PLEN)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .slot(slot), .field(field), .field_valid(field_valid), .bits_sent(bits_sent)
  );

  repetition_encoder #(.FIELD_SIZE(8), .LFSR_SEED(SEED8), .PREAMBLE_LEN(PLEN)) dut8 (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable8),
    .s_data(8'h00), .s_valid(1'b0), .s_ready(s_ready8),
    .slot(slot8), .field(field8), .field_valid(field_valid8), .bits_sent(bits_sent8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_prev = 16'h0000;
    m_bits = 0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One enabled slot; rep selects repeat vs fresh, payload counts toward bits_sent.
  task automatic do_slot(input string tag, input bit rep, input bit payload);
    logic [15:0] exp;
    if (rep) begin
      exp = m_prev;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      exp    = m_lfsr;
      if (exp == m_prev) exp = exp + 16'h0001;
    end
    m_prev = exp;
    if (payload) m_bits++;
    @(negedge sys_clk);
    slot = 1'b1;
    @(negedge sys_clk);
    slot = 1'b0;
    chk({tag, "_valid"}, field_valid, 1'b1);
    chk({tag, "_field"}, field, exp);
  endtask

  task automatic slot_disabled();
    @(negedge sys_clk);
    slot = 1'b1;
    @(negedge sys_clk);
    slot = 1'b0;
    chk("dis_valid", field_valid, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge sys_clk);
    chk("byte_ready", s_ready, 1'b1);
    @(negedge sys_clk);
    s_valid = 1'b0;
  endtask

  task automatic preamble_slots();
`ifdef REP_ENC_PREAMBLE_EN
    for (int i = 0; i < PLEN; i++) do_slot("pre", 1'b1, 1'b0);
    chk("pre_bits", bits_sent, m_bits);
`endif
  endtask

  task automatic send_bits(input string tag, input logic [7:0] b);
    preamble_slots();
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) chk({tag, "_busy"}, s_ready, 1'b0);
      do_slot(tag, b[i], 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2;
    chk("rst_field", field, 16'h0000);
    chk("rst_valid", field_valid, 1'b0);
    chk("rst_bits", bits_sent, 16'h0000);
    chk("rst_ready", s_ready, 1'b1);
    @(negedge sys_clk);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Fillers only.
    for (int i = 0; i < 3; i++) begin
      do_slot("fill", 1'b0, 1'b0);
      chk("fill_ready", s_ready, 1'b1);
    end
    chk("fill_bits", bits_sent, 16'd0);

    // 0xA5 -> R,F,R,F,F,R,F,R
    do_reset();
    send_byte(8'hA5);
    send_bits("a5", 8'hA5);
    chk("a5_bits", bits_sent, 16'd8);
    chk("a5_ready", s_ready, 1'b1);

    // 0xFF then 0x00 with s_valid held high throughout.
    do_reset();
    @(negedge sys_clk);
    s_data  = 8'hFF;
    s_valid = 1'b1;
    @(negedge sys_clk);
    s_data = 8'h00;
    chk("hold_busy", s_ready, 1'b0);
    send_bits("ff", 8'hFF);
    chk("hold_ready", s_ready, 1'b1);
    @(negedge sys_clk);
    s_valid = 1'b0;
    chk("hold_accept2", s_ready, 1'b0);
    send_bits("z0", 8'h00);
    chk("hold_bits", bits_sent, 16'd16);

    // 0x81 with enable dropped after three payload slots.
    do_reset();
    send_byte(8'h81);
    preamble_slots();
    do_slot("e1", 1'b1, 1'b1);
    do_slot("e0", 1'b0, 1'b1);
    do_slot("e0", 1'b0, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) slot_disabled();
    chk("dis_bits", bits_sent, 16'd3);
    chk("dis_ready", s_ready, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) do_slot("r0", 1'b0, 1'b1);
    do_slot("r1", 1'b1, 1'b1);
    chk("r_ready", s_ready, 1'b1);
    do_slot("r_fill", 1'b0, 1'b0);
    chk("r_bits", bits_sent, 16'd8);

    // 8-bit instance: first fresh is 0xFF, second candidate collides and wraps to 0x00.
    enable8 = 1'b1;
    @(negedge sys_clk);
    slot8 = 1'b1;
    @(negedge sys_clk);
    slot8 = 1'b0;
    chk("w_valid1", field_valid8, 1'b1);
    chk("w_field1", field8, 8'hFF);
    @(negedge sys_clk);
    slot8 = 1'b1;
    @(negedge sys_clk);
    slot8 = 1'b0;
    chk("w_valid2", field_valid8, 1'b1);
    chk("w_wrap", field8, 8'h00);
    chk("w_bits", bits_sent8, 16'd0);

    // 0x00 (with preamble burst in macro builds), then reset mid-byte.
    do_reset();
    send_byte(8'h00);
    send_bits("p0", 8'h00);
    chk("p0_bits", bits_sent, 16'd8);
    send_byte(8'hC3);
    do_slot("mid", 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_field", field, 16'h0000);
    chk("mr_valid", field_valid, 1'b0);
    chk("mr_bits", bits_sent, 16'h0000);
    chk("mr_ready", s_ready, 1'b1);
    @(negedge sys_clk);
    reset_n = 1'b1;
    model_reset();
    do_slot("mr_fill", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
